// File: rtl/bn_sequencer.sv
// Frame sequencer for per-channel batch normalisation: y = (x - mean) * gamma * inv_std + beta.
// Streams CHANNELS*FEATURE_SIZE^2 pixels per frame through a three-stage stallable pipeline.
module bn_sequencer #(
  parameter int unsigned CHANNELS     = 32,
  parameter int unsigned FEATURE_SIZE = 32,
  parameter int unsigned BIT_WIDTH    = 16,
  parameter int unsigned FRAC_BITS    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [1:0]                  cfg_sel,
  input  logic [$clog2(CHANNELS)-1:0] cfg_addr,
  input  logic [BIT_WIDTH-1:0]        cfg_data,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        err_cfg,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIT_WIDTH-1:0]        in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIT_WIDTH-1:0]        out_data,
  output logic                        out_last
);

  localparam int unsigned AW    = $clog2(CHANNELS);
  localparam int unsigned TOTAL = CHANNELS * FEATURE_SIZE * FEATURE_SIZE;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned C1W   = BIT_WIDTH + 1;
  localparam int unsigned PW    = 2 * BIT_WIDTH + 1;
  localparam int unsigned FW    = 3 * BIT_WIDTH + 2;
  localparam logic signed [BIT_WIDTH-1:0] One = BIT_WIDTH'(1 << FRAC_BITS);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic signed [BIT_WIDTH-1:0] gamma_q   [CHANNELS];
  logic signed [BIT_WIDTH-1:0] beta_q    [CHANNELS];
  logic signed [BIT_WIDTH-1:0] mean_q    [CHANNELS];
  logic signed [BIT_WIDTH-1:0] inv_std_q [CHANNELS];

  logic [CW-1:0] in_cnt_q;
  logic [AW-1:0] ch_cnt_q;
  logic          err_q;

  logic                  s1_valid_q, s2_valid_q, s3_valid_q;
  logic                  s1_last_q, s2_last_q, s3_last_q;
  logic [AW-1:0]         s1_ch_q, s2_ch_q;
  logic signed [C1W-1:0] s1_c_q;
  logic signed [PW-1:0]  s2_p_q;
  logic [BIT_WIDTH-1:0]  s3_data_q;

  logic adv, in_fire, out_fire, last_in, start_ok, addr_ok, cfg_ok, cfg_bad;
  logic signed [C1W-1:0] c_d;
  logic signed [PW-1:0]  p_d;
  logic signed [FW-1:0]  m_d, y_d;
  logic [FW-BIT_WIDTH:0] y_hi;
  logic [BIT_WIDTH-1:0]  y_sat;

  // Whole pipeline moves as one; it only holds when the output register is full and blocked.
  assign adv      = !s3_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_in  = (in_cnt_q == CW'(TOTAL - 1));
  assign start_ok = (state_q == StIdle) && start;
  assign addr_ok  = (32'(cfg_addr) < CHANNELS);
  assign cfg_ok   = cfg_we && (state_q == StIdle) && addr_ok;
  assign cfg_bad  = cfg_we && !cfg_ok;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (in_fire && last_in) state_d = StDrain;
      StDrain: if (out_fire && s3_last_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q != StIdle);
    in_ready = (state_q == StRun) && (in_cnt_q < CW'(TOTAL)) && adv;
    done     = (state_q == StDrain) && out_fire && s3_last_q;
  end

  assign err_cfg   = err_q;
  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;
  assign out_last  = s3_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        gamma_q[i]   <= One;
        inv_std_q[i] <= One;
        mean_q[i]    <= '0;
        beta_q[i]    <= '0;
      end
    end else if (cfg_ok) begin
      case (cfg_sel)
        2'd0:    gamma_q[cfg_addr]   <= cfg_data;
        2'd1:    beta_q[cfg_addr]    <= cfg_data;
        2'd2:    mean_q[cfg_addr]    <= cfg_data;
        default: inv_std_q[cfg_addr] <= cfg_data;
      endcase
    end
  end

  // A rejected write in the same cycle as start still leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_q <= 1'b0;
    else if (cfg_bad)  err_q <= 1'b1;
    else if (start_ok) err_q <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q <= '0;
      ch_cnt_q <= '0;
    end else if (start_ok) begin
      in_cnt_q <= '0;
      ch_cnt_q <= '0;
    end else if (in_fire) begin
      in_cnt_q <= in_cnt_q + 1'b1;
      ch_cnt_q <= (ch_cnt_q == AW'(CHANNELS - 1)) ? '0 : ch_cnt_q + 1'b1;
    end
  end

  always_comb begin
    c_d  = C1W'($signed(in_data)) - C1W'(mean_q[ch_cnt_q]);
    p_d  = PW'(s1_c_q) * PW'(gamma_q[s1_ch_q]);
    m_d  = FW'(s2_p_q) * FW'(inv_std_q[s2_ch_q]);
    y_d  = (m_d >>> (2 * FRAC_BITS)) + FW'(beta_q[s2_ch_q]);
    y_hi = y_d[FW-1:BIT_WIDTH-1];
    if (y_hi == '0 || y_hi == '1) y_sat = y_d[BIT_WIDTH-1:0];
    else if (y_d[FW-1])           y_sat = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    else                          y_sat = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      s3_last_q  <= 1'b0;
      s1_ch_q    <= '0;
      s2_ch_q    <= '0;
      s1_c_q     <= '0;
      s2_p_q     <= '0;
      s3_data_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        s1_c_q    <= c_d;
        s1_ch_q   <= ch_cnt_q;
        s1_last_q <= last_in;
      end
      s2_valid_q <= s1_valid_q;
      s2_p_q     <= p_d;
      s2_ch_q    <= s1_ch_q;
      s2_last_q  <= s1_valid_q && s1_last_q;
      s3_valid_q <= s2_valid_q;
      s3_data_q  <= y_sat;
      s3_last_q  <= s2_valid_q && s2_last_q;
    end
  end

endmodule

// File: tb/tb_bn_sequencer.sv
// Scoreboard bench for bn_sequencer: a behavioural model queues expected outputs per input
// handshake; a negedge monitor pops and compares on every output handshake.
module tb_bn_sequencer;

  localparam int CH    = 2;
  localparam int FS    = 2;
  localparam int BW    = 16;
  localparam int FB    = 8;
  localparam int TOTAL = CH * FS * FS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we, start, in_valid;
  logic [1:0]    cfg_sel;
  logic [0:0]    cfg_addr;
  logic [BW-1:0] cfg_data, in_data;
  logic          busy, done, err_cfg, in_ready, out_valid, out_last;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;

  bn_sequencer #(
    .CHANNELS    (CH),
    .FEATURE_SIZE(FS),
    .BIT_WIDTH   (BW),
    .FRAC_BITS   (FB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err_cfg  (err_cfg),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference parameters, tracked as the bench believes the DUT holds them.
  logic signed [BW-1:0] m_gamma [CH];
  logic signed [BW-1:0] m_beta  [CH];
  logic signed [BW-1:0] m_mean  [CH];
  logic signed [BW-1:0] m_inv   [CH];

  function automatic void model_identity();
    for (int i = 0; i < CH; i++) begin
      m_gamma[i] = 16'sh0100;
      m_inv[i]   = 16'sh0100;
      m_mean[i]  = '0;
      m_beta[i]  = '0;
    end
  endfunction

  function automatic logic [BW-1:0] model(input logic [BW-1:0] x, input int ch);
    longint c, m, y;
    c = longint'($signed(x)) - longint'(m_mean[ch]);
    m = c * longint'(m_gamma[ch]) * longint'(m_inv[ch]);
    y = (m >>> (2 * FB)) + longint'(m_beta[ch]);
    if (y > 32767) return 16'h7fff;
    if (y < -32768) return 16'h8000;
    return y[BW-1:0];
  endfunction

  logic [BW:0]   sb [$];
  logic [BW-1:0] stim [TOTAL];
  int            cyc = 0;
  int            done_cnt = 0;
  int            first_out_cyc = -1;
  int            hs_first, hs_last;
  logic          prev_stall = 1'b0;
  logic [BW:0]   prev_out;
  logic          bp_mode = 1'b0;
  int            bp_idx = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      out_ready = (bp_idx % 3 == 0);
      bp_idx++;
    end else begin
      out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [BW:0] exp;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (prev_stall) check_eq("hold", {out_valid, out_last, out_data}, {1'b1, prev_out});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_empty", sb.size(), 1);
        end else begin
          exp = sb.pop_front();
          check_eq("out_data", out_data, exp[BW-1:0]);
          check_eq("out_last", out_last, exp[BW]);
          check_eq("done", done, exp[BW]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int sel, input int addr, input logic [BW-1:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel[1:0];
    cfg_addr = addr[0:0];
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic set_params(input int ch, input logic [BW-1:0] g, input logic [BW-1:0] b,
                            input logic [BW-1:0] mu, input logic [BW-1:0] inv);
    cfg_write(0, ch, g);
    cfg_write(1, ch, b);
    cfg_write(2, ch, mu);
    cfg_write(3, ch, inv);
    m_gamma[ch] = g;
    m_beta[ch]  = b;
    m_mean[ch]  = mu;
    m_inv[ch]   = inv;
  endtask

  task automatic do_start();
    first_out_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      in_valid = 1'b1;
      in_data  = stim[i];
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        check_eq("in_timeout", t, 0);
        in_valid = 1'b0;
        return;
      end
      if (i == 0) hs_first = cyc;
      hs_last = cyc;
      sb.push_back({(i == TOTAL - 1), model(stim[i], i % CH)});
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_frame(input int target);
    int t = 0;
    while (done_cnt < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq("frame_done", done_cnt, target);
    tick();
    check_eq("busy_after", busy, 0);
    check_eq("done_after", done, 0);
    check_eq("sb_left", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err_cfg, 0);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_out_last"}, out_last, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    start = 1'b0;
    cfg_we = 1'b0;
    sb.delete();
    model_identity();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic fill(input logic [BW-1:0] v);
    for (int i = 0; i < TOTAL; i++) stim[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    model_identity();
    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Identity frame: latency and throughput
    fill(16'h0100);
    do_start();
    send(TOTAL);
    wait_frame(1);
    check_eq("latency", first_out_cyc - hs_first, 3);
    check_eq("throughput", hs_last - hs_first, TOTAL - 1);

    // Channel 1 parameters
    set_params(1, 16'h0200, 16'h0040, 16'h0080, 16'h0100);
    fill(16'h0180);
    do_start();
    send(TOTAL);
    wait_frame(2);

    // Backpressure with identity parameters
    reset_dut();
    bp_mode = 1'b1;
    bp_idx = 0;
    fill(16'h0100);
    do_start();
    send(TOTAL);
    wait_frame(3);
    bp_mode = 1'b0;

    // Saturation high then low
    for (int c = 0; c < CH; c++) set_params(c, 16'h7fff, 16'h0000, 16'h0000, 16'h7fff);
    fill(16'h7fff);
    do_start();
    send(TOTAL);
    wait_frame(4);
    for (int c = 0; c < CH; c++) set_params(c, 16'h7fff, 16'h0000, 16'h7fff, 16'h7fff);
    fill(16'h8000);
    do_start();
    send(TOTAL);
    wait_frame(5);

    // Config write while busy is rejected and flagged
    reset_dut();
    do_start();
    cfg_write(0, 0, 16'h0300);
    check_eq("err_set", err_cfg, 1);
    fill(16'h0100);
    send(TOTAL);
    wait_frame(6);
    check_eq("err_sticky", err_cfg, 1);
    do_start();
    check_eq("err_clear", err_cfg, 0);
    send(TOTAL);
    wait_frame(7);

    // Reset mid-frame, then a clean frame with identity parameters
    set_params(0, 16'h0200, 16'h0010, 16'h0000, 16'h0100);
    for (int i = 0; i < TOTAL; i++) stim[i] = 16'(16'h0040 * (i + 1) - 16'h0100);
    do_start();
    send(3);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1 check_reset_outputs("mid");
    sb.delete();
    model_identity();
    @(negedge clk);
    rst = 1'b0;
    tick();
    repeat (5) tick();
    check_eq("no_done", done_cnt, 7);
    do_start();
    send(TOTAL);
    wait_frame(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
